// File: rtl/lcd_master_0_st_packet_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_IN Avalon-ST byte sources into one
// channelised stream, holding the grant from SOP to EOP. Output is registered.
module lcd_master_0_st_packet_arbiter #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 8,
    parameter int CHAN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHAN_W-1:0]        out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    input  logic                     out_ready,
    output logic                     err_nosop
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {S_IDLE, S_PKT} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_grant, r_last;
    logic               r_first;
    logic [IDX_W-1:0]   w_pick_hi, w_pick_lo, w_pick;
    logic               w_any_hi, w_any_lo, w_any;
    logic               w_load, w_accept;
    logic               w_sel_valid, w_sel_sop, w_sel_eop;
    logic [DATA_W-1:0]  w_sel_data;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_sop   = in_startofpacket[i];
                w_sel_eop   = in_endofpacket[i];
                w_sel_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Rotating priority as two lowest-index searches: above r_last first, then wrap to all.
    always_comb begin
        w_pick_hi = '0;
        w_any_hi  = 1'b0;
        w_pick_lo = '0;
        w_any_lo  = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_valid[i] && !w_any_hi && (IDX_W'(i) > r_last)) begin
                w_pick_hi = IDX_W'(i);
                w_any_hi  = 1'b1;
            end
            if (in_valid[i] && !w_any_lo) begin
                w_pick_lo = IDX_W'(i);
                w_any_lo  = 1'b1;
            end
        end
        w_any  = w_any_lo;
        w_pick = w_any_hi ? w_pick_hi : w_pick_lo;
    end

    assign w_load   = ~out_valid | out_ready;
    assign w_accept = (r_state == S_PKT) & w_sel_valid & w_load;

    always_comb begin
        in_ready = '0;
        if (r_state == S_PKT) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                in_ready[i] = w_load && (r_grant == IDX_W'(i));
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_PKT;
            S_PKT:   if (w_accept && w_sel_eop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_grant           <= '0;
            r_last            <= IDX_W'(NUM_IN - 1);
            r_first           <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            err_nosop         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_pick;
                r_first <= 1'b1;
            end
            if (w_accept) begin
                out_valid         <= 1'b1;
                out_data          <= w_sel_data;
                out_channel       <= CHAN_W'(r_grant);
                out_startofpacket <= w_sel_sop;
                out_endofpacket   <= w_sel_eop;
                err_nosop         <= r_first & ~w_sel_sop;
                r_first           <= 1'b0;
                if (w_sel_eop) r_last <= r_grant;
            end else begin
                err_nosop <= 1'b0;
                if (out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_master_0_st_packet_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// per-source packet scoreboard and a round-robin ordering model.
module tb_lcd_master_0_st_packet_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid, out_sop, out_eop, out_ready, err_nosop;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_channel;

    always #5 clk = ~clk;

    lcd_master_0_st_packet_arbiter #(.NUM_IN(N), .DATA_W(DW), .CHAN_W(CW)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_ready         (out_ready),
        .err_nosop         (err_nosop)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t       src_q [N][$];
    beat_t       exp_q [N][$];
    int unsigned order_q [$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          valid_pct = 100;
    bit          rand_ready = 1'b0;
    logic        ready_force = 1'b1;
    int          err_exp = 0;
    int          err_seen = 0;
    bit          in_pkt = 1'b0;
    int unsigned cur_ch = 0;
    bit          hold_pending = 1'b0;
    logic [18:0] hold_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned rr_next(input int unsigned last, input logic [N-1:0] mask);
        for (int unsigned k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return last;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_tb();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        order_q.delete();
        err_exp      = 0;
        err_seen     = 0;
        in_pkt       = 1'b0;
        hold_pending = 1'b0;
    endtask

    task automatic add_pkt(input int unsigned src, input int unsigned len, input bit nosop,
                           input logic [DW-1:0] d0, input bit inc);
        beat_t b;
        for (int unsigned k = 0; k < len; k++) begin
            b.d   = inc ? DW'(d0 + k) : DW'($urandom);
            b.sop = (k == 0) ? !nosop : (!inc && $urandom_range(15) == 0);
            b.eop = (k == len - 1);
            src_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
        if (nosop) err_exp++;
    endtask

    task automatic score();
        int unsigned c;
        beat_t       e;
        c = out_channel;
        if (c >= N) begin
            check("sb_chan_range", c, N - 1);
            return;
        end
        if (exp_q[c].size() == 0) begin
            check("sb_extra_beat", exp_q[c].size(), 1);
            return;
        end
        e = exp_q[c].pop_front();
        check("sb_beat", {out_data, out_sop, out_eop}, {e.d, e.sop, e.eop});
        if (in_pkt) check("sb_interleave", c, cur_ch);
        if (out_eop) begin
            in_pkt = 1'b0;
            order_q.push_back(c);
        end else begin
            in_pkt = 1'b1;
            cur_ch = c;
        end
    endtask

    task automatic sample();
        check("inrdy_onehot", 32'($onehot0(in_ready)), 1);
        if (in_ready != '0) check("inrdy_load", 32'(!out_valid || out_ready), 1);
        if (hold_pending)
            check("bp_hold", {out_valid, out_data, out_channel, out_sop, out_eop}, hold_val);
        hold_pending = out_valid && !out_ready;
        hold_val     = {out_valid, out_data, out_channel, out_sop, out_eop};
        if (err_nosop) err_seen++;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
        end
        if (out_valid && out_ready) score();
    endtask

    // Drive inputs on the falling edge, then sample just after.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                in_valid[i]          = 1'b1;
                in_data[i*DW +: DW]  = src_q[i][0].d;
                in_sop[i]            = src_q[i][0].sop;
                in_eop[i]            = src_q[i][0].eop;
            end else begin
                in_valid[i]          = 1'b0;
                in_data[i*DW +: DW]  = DW'($urandom);
                in_sop[i]            = 1'($urandom_range(1));
                in_eop[i]            = 1'($urandom_range(1));
            end
        end
        out_ready = rand_ready ? ($urandom_range(3) != 0) : ready_force;
        #1;
        sample();
    endtask

    task automatic wait_out(input string tag, output int k);
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    task automatic run_until_empty(input int budget, input string tag);
        int n;
        n = 0;
        while (!all_empty() && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(all_empty()), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = '0;
        repeat (2) @(negedge clk);
        clear_tb();
        reset = 1'b0;
    endtask

    initial begin
        int          k;
        int unsigned rem [N];
        int unsigned exp_ord [$];
        int unsigned last;
        logic [N-1:0] mask;

        reset = 1'b0; in_valid = '0; in_data = '0; in_sop = '0; in_eop = '0; out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_outs", {out_valid, out_data, out_channel, out_sop, out_eop, err_nosop}, 0);
        check("rst_inrdy", in_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic 4-beat packet from source 0
        add_pkt(0, 4, 1'b0, 8'h10, 1'b1);
        step();
        k = 0;
        while (!out_valid && k < 10) begin
            step();
            k++;
        end
        check("t2_latency", k, 2);
        for (int b = 0; b < 4; b++) begin
            check("t2_beat", {out_valid, out_channel, out_data, out_sop, out_eop},
                  {1'b1, 8'd0, 8'(8'h10 + b), b == 0, b == 3});
            step();
        end
        check("t2_done", 32'(out_valid), 0);

        // Single-beat packet then back-to-back follow-up from source 1
        add_pkt(1, 1, 1'b0, 8'hA5, 1'b1);
        add_pkt(1, 2, 1'b0, 8'h50, 1'b1);
        step();
        wait_out("t5_wait", k);
        check("t5_beat", {out_channel, out_data, out_sop, out_eop}, {8'd1, 8'hA5, 1'b1, 1'b1});
        check("t5_idle_inrdy", in_ready, 0);
        run_until_empty(100, "t5_drain");

        // First beat without SOP
        add_pkt(0, 3, 1'b1, 8'h60, 1'b1);
        step();
        wait_out("t6_wait", k);
        check("t6_first", {err_nosop, out_data, out_sop}, {1'b1, 8'h60, 1'b0});
        step();
        check("t6_pulse", 32'(err_nosop), 0);
        run_until_empty(100, "t6_drain");
        check("t6_err_count", err_seen, err_exp);

        // Backpressure mid-packet
        add_pkt(2, 8, 1'b0, 8'h80, 1'b1);
        step();
        wait_out("t4_wait", k);
        step();
        step();
        ready_force = 1'b0;
        repeat (3) begin
            step();
            check("t4_inrdy", in_ready, 0);
            check("t4_valid", 32'(out_valid), 1);
        end
        ready_force = 1'b1;
        run_until_empty(100, "t4_drain");

        // Asynchronous reset in the middle of a packet
        add_pkt(1, 6, 1'b0, 8'hC0, 1'b1);
        step();
        wait_out("t1_wait", k);
        step();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t1_outs", {out_valid, out_data, out_channel, out_sop, out_eop, err_nosop}, 0);
        check("t1_inrdy", in_ready, 0);
        repeat (2) @(negedge clk);
        clear_tb();
        in_valid = '0;
        reset    = 1'b0;

        // Round-robin ordering with every source continuously requesting
        do_reset();
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 3, 1'b0, 8'h00, 1'b0);
            add_pkt(i, 3, 1'b0, 8'h00, 1'b0);
            rem[i] = 2;
        end
        last = N - 1;
        for (int p = 0; p < 2 * N; p++) begin
            for (int i = 0; i < N; i++) mask[i] = (rem[i] != 0);
            last = rr_next(last, mask);
            exp_ord.push_back(last);
            rem[last]--;
        end
        run_until_empty(200, "t3_drain");
        check("t3_npkts", order_q.size(), exp_ord.size());
        for (int p = 0; p < exp_ord.size() && p < order_q.size(); p++)
            check("t3_order", order_q[p], exp_ord[p]);

        // Randomized traffic with bubbles, backpressure and missing SOPs
        do_reset();
        rand_ready = 1'b1;
        valid_pct  = 70;
        for (int p = 0; p < 40; p++)
            add_pkt($urandom_range(N - 1), $urandom_range(5, 1), $urandom_range(9) == 0,
                    8'h00, 1'b0);
        run_until_empty(5000, "rnd_drain");
        check("rnd_err_count", err_seen, err_exp);
        check("rnd_npkts", order_q.size(), 40);

        rand_ready = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
